// File: rtl/sdram_write_queue.sv
// sdram_write_queue
// In-order write buffer between byte/word producers and the SDRAM controller's
// toggle-handshake write port. Each entry becomes exactly one controller write.
// The head entry stays in the FIFO until the controller acknowledges it, so
// count includes the write that is currently in flight.
module sdram_write_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 25
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AW-1:0]          in_addr,
  input  logic [15:0]            in_data,
  input  logic                   in_byte,
  output logic [AW-1:0]          waddr,
  output logic [15:0]            din,
  output logic                   we,
  output logic                   we_req,
  input  logic                   we_ack,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drained
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_IDLE = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // Byte writes replicate the low byte into both lanes; the controller's
  // lane mask then selects whichever half the address points at.
  function automatic logic [15:0] f_lane_data(input logic [15:0] d, input logic is_byte);
    f_lane_data = is_byte ? {d[7:0], d[7:0]} : d;
  endfunction

  state_t          r_state;
  logic [AW-1:0]   r_mem_addr [DEPTH];
  logic [15:0]     r_mem_data [DEPTH];
  logic            r_mem_byte [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_waddr;
  logic [15:0]     r_din;
  logic            r_we;
  logic            r_we_req;

  logic            w_full;
  logic            w_empty;
  logic            w_in_ready;
  logic            w_push;
  logic            w_pop;

  // A full queue refuses pushes even when a pop lands in the same cycle.
  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == {CW{1'b0}});
  assign w_in_ready = !w_full && (r_state != S_SYNC);
  assign w_push     = in_valid && w_in_ready;
  assign w_pop      = (r_state == S_WAIT) && (we_ack == r_we_req);

  assign in_ready = w_in_ready;
  assign count    = r_count;
  assign drained  = w_empty && (r_state == S_IDLE);
  assign waddr    = r_waddr;
  assign din      = r_din;
  assign we       = r_we;
  assign we_req   = r_we_req;

  // Entry storage: written at the tail on push, no reset needed for payload.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= in_addr;
      r_mem_data[r_wr_ptr] <= f_lane_data(in_data, in_byte);
      r_mem_byte[r_wr_ptr] <= in_byte;
    end
  end

  // Tail/head pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Controller handshake FSM: realign the toggle pair, launch head, wait for ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_SYNC;
      r_waddr  <= {AW{1'b0}};
      r_din    <= 16'h0000;
      r_we     <= 1'b0;
      r_we_req <= 1'b0;
    end else begin
      case (r_state)
        S_SYNC: begin
          // Adopt the controller's ack level so a write it was still finishing
          // when we reset is not mistaken for a fresh request.
          r_we_req <= we_ack;
          r_state  <= S_IDLE;
        end
        S_IDLE: begin
          if (!w_empty) begin
            r_waddr  <= r_mem_addr[r_rd_ptr];
            r_din    <= r_mem_data[r_rd_ptr];
            r_we     <= r_mem_byte[r_rd_ptr];
            r_we_req <= ~r_we_req;
            r_state  <= S_WAIT;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (we_ack == r_we_req) begin
            r_we    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        default: begin
          r_we    <= 1'b0;
          r_state <= S_SYNC;
        end
      endcase
    end
  end

endmodule
